// File: rtl/fwd_hazard_ctl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline: shadows the
// ID/EX, EX/MEM and MEM/WB register fields and drives the EX operand mux selects.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_ctl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_regwr,
    input  logic            id_memrd,
    input  logic            flush,
    output logic            stall,
    output logic            fwd_a_wb,
    output logic            fwd_a_mem,
    output logic            fwd_b_wb,
    output logic            fwd_b_mem
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (RA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("fwd_hazard_ctl: RA_W and CNT_W must be at least 1");
    end

    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic            ex_regwr, ex_memrd;
    logic [RA_W-1:0] mem_rd, wb_rd;
    logic            mem_regwr, wb_regwr;
    logic            hz;
    logic            bubble;

    // A load still in EX cannot supply its data to the instruction in ID yet.
    assign hz = id_valid & ex_memrd & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign stall  = hz & ~flush;
    assign bubble = stall | flush | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_regwr  <= 1'b0;
            ex_memrd  <= 1'b0;
            mem_rd    <= '0;
            mem_regwr <= 1'b0;
            wb_rd     <= '0;
            wb_regwr  <= 1'b0;
        end else begin
            // NOTE: a bubble also clears the addresses so stale rs/rd fields can never match.
            if (bubble) begin
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
                ex_regwr <= 1'b0;
                ex_memrd <= 1'b0;
            end else begin
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
                ex_regwr <= id_regwr;
                ex_memrd <= id_memrd;
            end
            mem_rd    <= ex_rd;
            mem_regwr <= ex_regwr;
            wb_rd     <= mem_rd;
            wb_regwr  <= mem_regwr;
        end
    end

    // Both selects may be set together; mux2 sits after mux1 so MEM wins.
    always_comb begin
        fwd_a_mem = mem_regwr & (mem_rd != '0) & (mem_rd == ex_rs1);
        fwd_a_wb  = wb_regwr  & (wb_rd  != '0) & (wb_rd  == ex_rs1);
        fwd_b_mem = mem_regwr & (mem_rd != '0) & (mem_rd == ex_rs2);
        fwd_b_wb  = wb_regwr  & (wb_rd  != '0) & (wb_rd  == ex_rs2);
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctl.sv
// Scoreboard bench for fwd_hazard_ctl: directed pipeline scenarios followed by
// random instruction streams, checked against an in-flight instruction model.
module tb_fwd_hazard_ctl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic            valid;
        logic            regwr;
        logic            memrd;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } ins_t;

    typedef struct packed {
        logic             stall;
        logic             fa_wb;
        logic             fa_mem;
        logic             fb_wb;
        logic             fb_mem;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_regwr, id_memrd;
    logic            flush;
    logic            stall;
    logic            fwd_a_wb, fwd_a_mem, fwd_b_wb, fwd_b_mem;
`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    fwd_hazard_ctl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_regwr  (id_regwr),
        .id_memrd  (id_memrd),
        .flush     (flush),
        .stall     (stall),
        .fwd_a_wb  (fwd_a_wb),
        .fwd_a_mem (fwd_a_mem),
        .fwd_b_wb  (fwd_b_wb),
        .fwd_b_mem (fwd_b_mem)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: the instructions currently occupying EX, MEM and WB.
    ins_t             m_ex, m_mem, m_wb;
    logic [CNT_W-1:0] m_cnt;
    logic             last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // An older instruction supplies register r if it writes r and r is not x0.
    function automatic logic supplies(input ins_t p, input logic [RA_W-1:0] r);
        return p.valid && p.regwr && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic logic load_use(input ins_t ld, input ins_t c);
        return c.valid && ld.valid && ld.memrd && (ld.rd != 0) &&
               (ld.rd == c.rs1 || ld.rd == c.rs2);
    endfunction

    function automatic ins_t mk(input logic v, input int rs1, input int rs2,
                                input int rd, input logic wr, input logic ld);
        ins_t i;
        i.valid = v;
        i.rs1   = RA_W'(rs1);
        i.rs2   = RA_W'(rs2);
        i.rd    = RA_W'(rd);
        i.regwr = wr;
        i.memrd = ld;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.valid = ($urandom_range(0, 9) != 0);
        i.rs1   = RA_W'($urandom_range(0, 7));
        i.rs2   = RA_W'($urandom_range(0, 7));
        i.rd    = RA_W'($urandom_range(0, 7));
        i.memrd = ($urandom_range(0, 2) == 0);
        i.regwr = i.memrd | ($urandom_range(0, 3) != 0);
        return i;
    endfunction

    // One clock cycle: present ID inputs, queue the expected response, advance the model.
    task automatic drive(input ins_t i, input logic fl, input logic r);
        exp_t e;
        logic st;
        id_valid = i.valid;
        id_rs1   = i.rs1;
        id_rs2   = i.rs2;
        id_rd    = i.rd;
        id_regwr = i.regwr;
        id_memrd = i.memrd;
        flush    = fl;
        rst      = r;
        st       = load_use(m_ex, i) && !fl;
        e.stall  = st;
        e.fa_mem = supplies(m_mem, m_ex.rs1) && m_ex.valid;
        e.fa_wb  = supplies(m_wb,  m_ex.rs1) && m_ex.valid;
        e.fb_mem = supplies(m_mem, m_ex.rs2) && m_ex.valid;
        e.fb_wb  = supplies(m_wb,  m_ex.rs2) && m_ex.valid;
        e.cnt    = m_cnt;
        if (!r) exp_q.push_back(e);
        last_stall = r ? 1'b0 : st;
        @(posedge clk);
        if (r) begin
            m_ex  = '0;
            m_mem = '0;
            m_wb  = '0;
            m_cnt = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (st || fl || !i.valid) ? ins_t'('0) : i;
            if (st && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    // Issue an instruction, holding it in ID for as long as the model expects a stall.
    task automatic issue(input ins_t i, input logic fl);
        int guard;
        drive(i, fl, 1'b0);
        guard = 0;
        while (last_stall && guard < 4) begin
            drive(i, fl, 1'b0);
            guard++;
        end
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue(mk(0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",     32'(stall),     32'(e.stall));
            check("fwd_a_mem", 32'(fwd_a_mem), 32'(e.fa_mem));
            check("fwd_a_wb",  32'(fwd_a_wb),  32'(e.fa_wb));
            check("fwd_b_mem", 32'(fwd_b_mem), 32'(e.fb_mem));
            check("fwd_b_wb",  32'(fwd_b_wb),  32'(e.fb_wb));
`ifdef FWD_STALL_CNT_EN
            check("stall_cnt", stall_cnt,      e.cnt);
`endif
        end
    end

    initial begin
        ins_t cur;
        m_ex       = '0;
        m_mem      = '0;
        m_wb       = '0;
        m_cnt      = '0;
        last_stall = 1'b0;

        // Reset with random inputs for two cycles.
        drive(rand_ins(), 1'($urandom_range(0, 1)), 1'b1);
        drive(rand_ins(), 1'($urandom_range(0, 1)), 1'b1);
        nops(2);

        // EX->EX: add x5, then a reader of x5 in rs1.
        issue(mk(1, 1, 2, 5, 1, 0), 1'b0);
        issue(mk(1, 5, 0, 6, 1, 0), 1'b0);
        nops(3);

        // MEM->EX with priority: two writers of x7, then a reader in rs2.
        issue(mk(1, 1, 1, 7, 1, 0), 1'b0);
        issue(mk(1, 2, 2, 7, 1, 0), 1'b0);
        issue(mk(1, 0, 7, 8, 1, 0), 1'b0);
        nops(3);

        // Load-use: load x3, then a reader of x3 (held one cycle by the stall).
        issue(mk(1, 1, 0, 3, 1, 1), 1'b0);
        issue(mk(1, 3, 0, 9, 1, 0), 1'b0);
        nops(3);

        // x0 guard: load to x0, then a reader of x0.
        issue(mk(1, 1, 0, 0, 1, 1), 1'b0);
        issue(mk(1, 0, 0, 10, 1, 0), 1'b0);
        nops(3);

        // Flush beats the load-use hazard.
        issue(mk(1, 1, 0, 4, 1, 1), 1'b0);
        issue(mk(1, 4, 4, 11, 1, 0), 1'b1);
        nops(3);

        // Random streams with occasional flushes and mid-stream resets.
        cur = rand_ins();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive(rand_ins(), 1'($urandom_range(0, 1)), 1'b1);
                drive(rand_ins(), 1'($urandom_range(0, 1)), 1'b1);
                last_stall = 1'b0;
            end
            if (!last_stall) cur = rand_ins();
            drive(cur, ($urandom_range(0, 9) == 0), 1'b0);
        end
        nops(2);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
